// File: rtl/rsa_params.sv
// rtl/rsa_params.sv - shared modexp operand width, modulus and Montgomery constants
package rsa_params;
   localparam int K = 192;
   localparam int LOGK = 8;
   localparam logic [K-1:0] M  = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;
   localparam logic [K-1:0] R1 = 192'h000000000000000000000000000000010000000000000001;
   localparam logic [K-1:0] R2 = 192'h000000000000000100000000000000020000000000000001;
endpackage

// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - radix-2 Montgomery multiplier, z = a*b*2^-K mod M
module mod_mul #(
   parameter int           K = rsa_params::K,
   parameter logic [K-1:0] M = rsa_params::M
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [K-1:0] a,
   input  logic [K-1:0] b,
   output logic         done,
   output logic [K-1:0] z
);
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {M_IDLE, M_RUN, M_FIX, M_END} mstate_t;

   mstate_t        st, st_nxt;
   logic           start_d;
   logic           launch;
   logic [K-1:0]   a_r, b_r;
   logic [K+1:0]   t, s1, s2, t_sub;
   logic           t_ge_m;
   logic [CW-1:0]  cnt;

   // only a fresh rising edge of start launches, and only when not mid-op
   assign launch = start & ~start_d & ((st == M_IDLE) | (st == M_END));
   assign done   = (st == M_END);

   always_comb begin
      s1     = t + (a_r[0] ? {2'b00, b_r} : '0);
      s2     = s1[0] ? (s1 + {2'b00, M}) : s1;
      t_sub  = t - {2'b00, M};
      t_ge_m = (t >= {2'b00, M});
   end

   always_comb begin
      st_nxt = st;
      case (st)
         M_IDLE, M_END: if (launch) st_nxt = M_RUN;
         M_RUN:         if (cnt == CW'(K - 1)) st_nxt = M_FIX;
         M_FIX:         st_nxt = M_END;
         default:       st_nxt = M_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= M_IDLE;
         start_d <= 1'b0;
         a_r     <= '0;
         b_r     <= '0;
         t       <= '0;
         cnt     <= '0;
         z       <= '0;
      end else begin
         st      <= st_nxt;
         start_d <= start;
         if (launch) begin
            a_r <= a;
            b_r <= b;
            t   <= '0;
            cnt <= '0;
         end else if (st == M_RUN) begin
            t   <= {1'b0, s2[K+1:1]};
            a_r <= a_r >> 1;
            cnt <= cnt + CW'(1);
         end else if (st == M_FIX) begin
            z <= t_ge_m ? t_sub[K-1:0] : t[K-1:0];
         end
      end
   end
endmodule

// File: rtl/mod_exp.sv
// rtl/mod_exp.sv - Montgomery modular exponentiation controller driving mod_mul
module mod_exp #(
   parameter int           K    = rsa_params::K,
   parameter int           LOGK = rsa_params::LOGK,
   parameter logic [K-1:0] M    = rsa_params::M,
   parameter logic [K-1:0] R1   = rsa_params::R1,
   parameter logic [K-1:0] R2   = rsa_params::R2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [K-1:0] x,
   input  logic [K-1:0] e,
   output logic         busy,
   output logic         done,
   output logic [K-1:0] z
);
   typedef enum logic [2:0] {
      S_IDLE, S_TO_MONT, S_SQUARE, S_MULT, S_FROM_MONT, S_DONE
   } state_t;
   typedef enum logic [1:0] {P_ISSUE, P_WAIT_LO, P_WAIT_HI} phase_t;

   state_t          state, ns;
   phase_t          phase, np;
   logic            issue_cnt;
   logic [LOGK-1:0] i;
   logic [K-1:0]    x_reg, e_reg, a, xm, op_a, op_b;
   logic [K-1:0]    a_new, xm_new, nxt_a, nxt_b;
   logic            mm_start, mm_done;
   logic [K-1:0]    mm_z;
   logic            accept, op_end, e_bit, bit_step, in_op;

   assign in_op    = (state != S_IDLE) && (state != S_DONE);
   assign accept   = start && !in_op;
   assign op_end   = in_op && (phase == P_WAIT_HI) && mm_done;
   assign e_bit    = e_reg[i];
   assign bit_step = op_end && (((state == S_SQUARE) && !e_bit) || (state == S_MULT));

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         phase     <= P_ISSUE;
         issue_cnt <= 1'b0;
      end else begin
         state     <= ns;
         phase     <= np;
         issue_cnt <= (in_op && (phase == P_ISSUE)) ? ~issue_cnt : 1'b0;
      end
   end

   // next-state logic
   always_comb begin
      ns = state;
      np = phase;
      if (!in_op) begin
         if (start) begin
            ns = S_TO_MONT;
            np = P_ISSUE;
         end
      end else begin
         case (phase)
            P_ISSUE:   if (issue_cnt) np = P_WAIT_LO;
            P_WAIT_LO: if (!mm_done) np = P_WAIT_HI;
            P_WAIT_HI: if (mm_done) begin
               np = P_ISSUE;
               case (state)
                  S_TO_MONT:   ns = S_SQUARE;
                  S_SQUARE:    ns = e_bit ? S_MULT : ((i == '0) ? S_FROM_MONT : S_SQUARE);
                  S_MULT:      ns = (i == '0) ? S_FROM_MONT : S_SQUARE;
                  S_FROM_MONT: ns = S_DONE;
                  default:     ns = S_IDLE;
               endcase
            end
            default:   np = P_ISSUE;
         endcase
      end
   end

   // output decode
   always_comb begin
      mm_start = in_op && (phase == P_ISSUE);
   end

   // operands for the next op use the result being captured this cycle
   always_comb begin
      a_new  = (state == S_TO_MONT) ? a : mm_z;
      xm_new = (state == S_TO_MONT) ? mm_z : xm;
      nxt_a  = op_a;
      nxt_b  = op_b;
      case (ns)
         S_SQUARE:    begin nxt_a = a_new; nxt_b = a_new;  end
         S_MULT:      begin nxt_a = a_new; nxt_b = xm_new; end
         S_FROM_MONT: begin nxt_a = a_new; nxt_b = K'(1);  end
         default:     ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_reg <= '0;
         e_reg <= '0;
         i     <= '0;
         a     <= '0;
         xm    <= '0;
         op_a  <= '0;
         op_b  <= '0;
         z     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else if (accept) begin
         x_reg <= x;
         e_reg <= e;
         i     <= LOGK'(K - 1);
         a     <= R1;
         op_a  <= x;
         op_b  <= R2;
         z     <= '0;
         busy  <= 1'b1;
         done  <= 1'b0;
      end else if (op_end) begin
         if (state == S_TO_MONT) xm <= mm_z;
         else                    a  <= mm_z;
         if (bit_step && (i != '0)) i <= i - LOGK'(1);
         op_a <= nxt_a;
         op_b <= nxt_b;
         if (state == S_FROM_MONT) begin
            z    <= mm_z;
            done <= 1'b1;
            busy <= 1'b0;
         end
      end
   end

   mod_mul #(.K(K), .M(M)) u_mm (
      .clk   (clk),
      .rst_n (~rst),
      .start (mm_start),
      .a     (op_a),
      .b     (op_b),
      .done  (mm_done),
      .z     (mm_z)
   );
endmodule

// File: tb/tb_mod_exp.sv
// tb/tb_mod_exp.sv - directed self-checking bench for mod_exp at a reduced 32-bit width
module tb_mod_exp;
   localparam int          KB  = 32;
   localparam logic [31:0] MB  = 32'hFFFFFFFB;
   localparam logic [31:0] R1B = 32'd5;
   localparam logic [31:0] R2B = 32'd25;
   localparam int          LIMIT = 5000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] x_in = '0;
   logic [31:0] e_in = '0;
   logic        busy, done;
   logic [31:0] z;

   int errors = 0;
   int checks = 0;
   int rises  = 0;
   logic prev_ms = 1'b0;

   always #5 clk = ~clk;

   mod_exp #(.K(KB), .LOGK(5), .M(MB), .R1(R1B), .R2(R2B)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x_in),
      .e     (e_in),
      .busy  (busy),
      .done  (done),
      .z     (z)
   );

   always @(negedge clk) begin
      if (dut.mm_start && !prev_ms) rises++;
      prev_ms = dut.mm_start;
   end

   function automatic logic [31:0] model(input logic [31:0] b, input logic [31:0] ex);
      logic [63:0] r, bb;
      r  = 64'd1;
      bb = {32'd0, b} % {32'd0, MB};
      for (int k = 31; k >= 0; k--) begin
         r = (r * r) % {32'd0, MB};
         if (ex[k]) r = (r * bb) % {32'd0, MB};
      end
      return r[31:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic do_start(input logic [31:0] xv, input logic [31:0] ev);
      @(negedge clk);
      x_in  = xv;
      e_in  = ev;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, {31'd0, done}, 32'd1);
   endtask

   task automatic run(input logic [31:0] xv, input logic [31:0] ev,
                      input logic [31:0] expz, input string tag);
      do_start(xv, ev);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done(tag);
      check({tag, "_z"}, z, expz);
      check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_z", z, 32'd0);
      check("rst_mm_start", {31'd0, dut.mm_start}, 32'd0);
      rst = 1'b0;

      rises = 0;
      run(32'd2, 32'd3, 32'd8, "x2_e3");
      check("x2_e3_ops", rises, KB + 4);

      run(32'd5, 32'd0, 32'd1, "x5_e0");
      run(32'd0, 32'd7, 32'd0, "x0_e7");
      run(MB - 32'd1, 32'd2, 32'd1, "xm1_e2");
      run(32'd123456789, 32'd1, 32'd123456789, "x123456789_e1");
      repeat (20) @(negedge clk);
      check("hold_done", {31'd0, done}, 32'd1);
      check("hold_z", z, 32'd123456789);

      run(32'd2, 32'h8000_0000, model(32'd2, 32'h8000_0000), "x2_e2p31");
      x_in  = 32'd3;
      e_in  = 32'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("relaunch_done_drop", {31'd0, done}, 32'd0);
      check("relaunch_z_drop", z, 32'd0);
      check("relaunch_busy", {31'd0, busy}, 32'd1);
      wait_done("x3_e4");
      check("x3_e4_z", z, 32'd81);

      do_start(32'd10, 32'd5);
      repeat (5) @(negedge clk);
      x_in = 32'd11; e_in = 32'd9; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (50) @(negedge clk);
      x_in = 32'd12; e_in = 32'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (300) @(negedge clk);
      x_in = 32'd13; e_in = 32'd2; start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("ignore_busy", {31'd0, busy}, 32'd1);
      wait_done("ignore");
      check("ignore_z", z, 32'd100000);

      do_start(32'd9, 32'd3);
      n = 0;
      while (dut.state != 3'd2 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check("reach_square", {29'd0, dut.state}, 32'd2);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy_now", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_z", z, 32'd0);
      rst = 1'b0;
      run(32'd7, 32'd2, 32'd49, "x7_e2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
